ts_packet_selector: RTL
=======================

// Module: ts_packet_selector
// PURPOSE
//  N-channel MPEG2-TS input selector with packet-aligned switching and a single-clock output FIFO.
//  Picks one byte lane out of N_CH {data,valid,sync} channels and buffers it as {sync,data} entries.
//  Drives a valid/ready output stream toward the QoS rate stage.
//  A channel change takes effect only at a TS packet boundary, so no partial or spliced packets
//  are ever emitted.
// PARAMETERS
//  N_CH       4    number of TS input channels (>=2)
//  ADDR_WIDTH 4    FIFO depth = 2**ADDR_WIDTH entries of 9 bits ({sync,data[7:0]})
//  PKT_LEN    188  TS packet length in bytes
//  SEL_W      localparam = max(1,$clog2(N_CH))
// PORTS
//  clk         in   1             system clock (27 MHz domain)
//  rstn        in   1             async active-low reset
//  sel         in   SEL_W         requested channel; sampled only in HUNT
//  data_in     in   N_CH*8        channel i byte = data_in[8*i+7:8*i]
//  valid_in    in   N_CH          per-channel byte valid
//  sync_in     in   N_CH          per-channel packet-start flag (first byte, 0x47)
//  out_data    out  8             FIFO head byte
//  out_sync    out  1             FIFO head sync flag
//  out_valid   out  1             FIFO not empty (first-word-fall-through)
//  out_ready   in   1             consumer accepts head when out_valid&out_ready
//  fifo_level  out  ADDR_WIDTH+1  current FIFO occupancy, 0..2**ADDR_WIDTH
//  sel_active  out  SEL_W         channel currently forwarded
//  overflow    out  1             sticky: a byte was dropped on a full FIFO
//  clr_ovf     in   1             clears overflow (set wins if coincident)
// BEHAVIOUR
//  Reset (async, rstn=0): state=HUNT, sel_active=0, byte cnt=0, pipe empty, FIFO empty.
//   All outputs 0 (out_valid=0, fifo_level=0, overflow=0). Reset may hit mid-packet: the packet is abandoned.
//  FSM states:
//   HUNT: sel_active<=sel every cycle. A byte with valid&sync on lane sel_active is accepted, cnt<=1, ->PASS.
//    All other bytes are discarded. If sel>=N_CH, nothing is accepted.
//   PASS: sel_active frozen; every valid byte on sel_active is accepted, cnt++.
//    When the accepted byte has cnt==PKT_LEN-1: cnt<=0, ->HUNT. The next sel is picked up the following cycle.
//    sync on a byte with cnt!=0 is a resync: the byte is accepted as a new packet start, cnt<=1, stay in PASS.
//  Write path: an accepted byte goes to a pipe register {sync,data} at edge k, and is written to the FIFO at edge k+1.
//   out_valid rises after edge k+1 if the FIFO was empty (latency 2 edges).
//  Read: pop on out_valid&out_ready; rptr advances, head updates next cycle; no pop when empty.
//  Pointers: ADDR_WIDTH+1 bits, wrap naturally.
//   full  = (wptr^rptr)=={1,0..0}; empty = wptr==rptr; fifo_level = wptr-rptr.
//  Simultaneous push+pop: allowed in all states, including full (level unchanged) and empty (push only).
//  Overflow: pipe write when full with no same-cycle pop -> byte dropped, overflow<=1, FSM ->HUNT.
//   The rest of that packet is discarded; bytes already in the FIFO are still output.
//  clr_ovf=1 clears overflow next edge unless a new drop occurs that same cycle.
//  Bytes with valid=0 never change cnt or state.
// CONFIGURATION
//  TS_SEL_STATS_EN defined:
//   adds outputs pkt_count[15:0] (+1 per packet with PKT_LEN bytes written) and
//   drop_count[15:0] (+1 per dropped byte), both wrapping at 0xFFFF, 0 on reset, cleared by clr_ovf.
//  Not defined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 N_CH=4,sel=2, one 188-byte packet on ch2 (0x47,0x00..), out_ready=1
//    -> identical 188 bytes out, out_sync=1 only on 0x47, first out_valid 2 edges after 0x47 in.
//  2 sel 2->1 at byte 100 of a ch2 packet
//    -> remaining 88 ch2 bytes out, then next ch1 packet from its sync; sel_active=1 only after ch2 byte 187.
//  3 Ch2 bytes 0x10..0x1F without sync, then packet with sync
//    -> pre-sync bytes absent from output, fifo_level 0 before sync.
//  4 ADDR_WIDTH=4, out_ready=0, 20-byte burst
//    -> 16 bytes stored, fifo_level=16, overflow=1, 17th..20th dropped, FSM HUNT; clr_ovf -> overflow=0.
//  5 rstn pulsed low at byte 50 with FIFO holding 10
//    -> out_valid=0, fifo_level=0, sel_active=0 immediately; next packet accepted only from sync.
//  6 TS_SEL_STATS_EN: 3 full packets then test 4 stimulus
//    -> pkt_count=3, drop_count=4; clr_ovf -> both 0.

Source files
------------

// File: rtl/ts_packet_selector.sv
// ts_packet_selector
//   N-channel MPEG2-TS input selector. One byte lane is forwarded into a
//   first-word-fall-through FIFO of {sync,data} entries. A channel change is
//   only honoured at a TS packet boundary, so packets are never spliced.
//
//   Optional feature macro: TS_SEL_STATS_EN. When it is defined, the
//   pkt_count and drop_count statistics outputs are added.
//
// Ports
//   clk, rstn          system clock, async active-low reset
//   sel                requested channel (taken only while hunting)
//   data_in/valid_in/sync_in   per-channel byte lanes (lane i = data_in[8*i+:8])
//   out_data/out_sync/out_valid/out_ready   FIFO head, valid/ready stream
//   fifo_level         FIFO occupancy 0..2**ADDR_WIDTH
//   sel_active         channel currently forwarded
//   overflow/clr_ovf   sticky drop flag and its clear (set wins)
//   pkt_count/drop_count   (TS_SEL_STATS_EN only) wrapping statistics
//
// States
//   HUNT | waiting for a sync byte on sel_active; sel_active follows sel
//   PASS | inside a packet; sel_active frozen, every valid byte forwarded
module ts_packet_selector #(
  parameter int N_CH       = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int PKT_LEN    = 188,
  localparam int SEL_W     = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*8-1:0]     data_in,
  input  logic [N_CH-1:0]       valid_in,
  input  logic [N_CH-1:0]       sync_in,
  output logic [7:0]            out_data,
  output logic                  out_sync,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic [SEL_W-1:0]      sel_active,
  output logic                  overflow,
  input  logic                  clr_ovf
`ifdef TS_SEL_STATS_EN
  ,
  output logic [15:0]           pkt_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int CNT_W = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {HUNT = 1'b0, PASS = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic               accept, pkt_last;

  logic [7:0]         lane_data;
  logic               lane_valid, lane_sync;

  logic               pipe_vld, pipe_sync;
  logic [7:0]         pipe_data;

  logic [ADDR_WIDTH:0] wptr, rptr;
  logic [8:0]          mem [DEPTH];
  logic                full, empty, push, pop, drop;

  // Lane mux; an out-of-range sel_active matches no lane, so nothing is accepted.
  always_comb begin
    lane_data  = '0;
    lane_valid = 1'b0;
    lane_sync  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_active == SEL_W'(i)) begin
        lane_data  = data_in[8*i +: 8];
        lane_valid = valid_in[i];
        lane_sync  = sync_in[i];
      end
    end
  end

  assign empty = (wptr == rptr);
  assign full  = ((wptr ^ rptr) == {1'b1, {ADDR_WIDTH{1'b0}}});
  assign pop   = !empty && out_ready;
  assign push  = pipe_vld && (!full || pop);
  assign drop  = pipe_vld && full && !pop;

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= HUNT;
      cnt        <= '0;
      sel_active <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel_active <= sel_nxt;
    end
  end

  // FSM: next state. A drop abandons the packet being received.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_active;
    if (drop) begin
      state_nxt = HUNT;
      cnt_nxt   = '0;
    end else if (accept) begin
      if (lane_sync) begin
        // packet start, or a resync inside a packet
        state_nxt = PASS;
        cnt_nxt   = CNT_W'(1);
      end else if (pkt_last) begin
        state_nxt = HUNT;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
    // Held on the accepting cycle so the lane that delivered the sync is the
    // lane the rest of the packet is taken from.
    if (state == HUNT && !accept) sel_nxt = sel;
  end

  // FSM: outputs
  always_comb begin
    accept = 1'b0;
    if (lane_valid && !drop) begin
      case (state)
        HUNT:    accept = lane_sync;
        PASS:    accept = 1'b1;
        default: accept = 1'b0;
      endcase
    end
    pkt_last = accept && !lane_sync && (cnt == CNT_W'(PKT_LEN - 1));
  end

  // Pipe stage, FIFO pointers, overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_vld  <= 1'b0;
      pipe_sync <= 1'b0;
      pipe_data <= '0;
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
    end else begin
      pipe_vld  <= accept;
      pipe_sync <= lane_sync;
      pipe_data <= lane_data;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[ADDR_WIDTH-1:0]] <= {pipe_sync, pipe_data};
  end

  assign {out_sync, out_data} = empty ? 9'd0 : mem[rptr[ADDR_WIDTH-1:0]];
  assign out_valid  = !empty;
  assign fifo_level = wptr - rptr;

`ifdef TS_SEL_STATS_EN
  logic pipe_last, discard, lost;

  // After a drop, further bytes of the abandoned packet count as dropped
  // until the next accepted sync.
  assign lost = lane_valid && !accept && (drop || discard);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_last  <= 1'b0;
      discard    <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      pipe_last <= pkt_last;
      if (accept)    discard <= 1'b0;
      else if (drop) discard <= 1'b1;
      if (clr_ovf) begin
        pkt_count  <= '0;
        drop_count <= '0;
      end else begin
        pkt_count  <= pkt_count + 16'(push && pipe_last);
        drop_count <= drop_count + 16'(drop) + 16'(lost);
      end
    end
  end
`endif

endmodule
